// File: rtl/sniffer_pkg.sv
// Shared types and helpers for the sniffer's Avalon-ST packet streamer.
package sniffer_pkg;

    localparam int AVST_DATA_W  = 32;
    localparam int AVST_EMPTY_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } streamer_state_t;

    typedef struct packed {
        logic [AVST_DATA_W-1:0]  data;
        logic                    sop;
        logic                    eop;
        logic [AVST_EMPTY_W-1:0] empty;
    } beat_t;

    // Number of 32-bit words needed to carry nbytes bytes (rounded up).
    function automatic logic [10:0] bytes_to_words(input logic [11:0] nbytes);
        return 11'((13'(nbytes) + 13'd3) >> 2);
    endfunction

endpackage

// File: rtl/st_skid_fifo.sv
// Output skid FIFO of stream beats; entry 0 is the registered head, so the
// head drives the stream outputs straight from flops. Push and pop may coincide.
module st_skid_fifo
    import sniffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  beat_t                  push_beat,
    input  logic                   pop,
    output beat_t                  head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    beat_t          mem [DEPTH];
    logic           do_pop;
    logic           do_push;
    logic [AW-1:0]  widx;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
    // Entries shift toward the head on a pop, so the write slot slides down by one.
    assign widx    = AW'(count) - AW'(do_pop);
    assign head    = mem[0];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (do_push) begin
                mem[widx] <= push_beat;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/packet_streamer.sv
// Replays a stored frame from the capture buffer as an Avalon-ST source stream.
// Optional build macro PKT_STREAMER_STATS_EN adds tx_packets/tx_bytes counters.
module packet_streamer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = 4,
    parameter int MAX_BYTES  = 2048
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [11:0] byte_len,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic [31:0] data_out,
    output logic        valid,
    input  logic        ready,
    output logic        sop,
    output logic        eop,
    output logic [1:0]  empty
`ifdef PKT_STREAMER_STATS_EN
    ,
    output logic [63:0] tx_packets,
    output logic [63:0] tx_bytes
`endif
);

    import sniffer_pkg::*;

    localparam int BEAT_W = $clog2(MAX_BYTES / 4) + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    streamer_state_t   state;
    streamer_state_t   state_nxt;
    logic [BEAT_W-1:0] words;
    logic [BEAT_W-1:0] words_nxt;
    logic [BEAT_W-1:0] rd_idx;
    logic [1:0]        empty_last;
    logic [1:0]        empty_last_nxt;
    logic [11:0]       len_c;
    logic              zero_done;
    logic              accept;
    logic              last_rd;
    logic              rd_vld_p1;
    logic              sop_p1;
    logic              eop_p1;
    logic [1:0]        empty_p1;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occ;
    beat_t             push_beat;
    beat_t             head;
    logic              pop;

    assign len_c          = (byte_len > 12'(MAX_BYTES)) ? 12'(MAX_BYTES) : byte_len;
    assign words_nxt      = BEAT_W'(bytes_to_words(len_c));
    assign empty_last_nxt = 2'(3'd4 - {1'b0, len_c[1:0]});

    assign busy    = (state != IDLE) || zero_done;
    assign accept  = start && !busy;
    // The read in flight already owns a FIFO slot, which is what keeps a full FIFO from overflowing.
    assign occ     = fifo_count + CNT_W'(rd_vld_p1);
    assign last_rd = (rd_idx == words - BEAT_W'(1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = zero_done;
        case (state)
            IDLE: begin
                if (accept && (len_c != '0)) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (occ < CNT_W'(FIFO_DEPTH)) begin
                    rd_en = 1'b1;
                    if (last_rd) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((fifo_count == '0) && !rd_vld_p1) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: address / word counters and the read strobe
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_addr    <= '0;
            rd_idx     <= '0;
            words      <= '0;
            empty_last <= '0;
            zero_done  <= 1'b0;
            rd_vld_p1  <= 1'b0;
        end else begin
            zero_done <= accept && (len_c == '0);
            rd_vld_p1 <= rd_en;
            if (accept) begin
                rd_addr    <= base_addr;
                rd_idx     <= '0;
                words      <= words_nxt;
                empty_last <= empty_last_nxt;
            end else if (rd_en) begin
                rd_addr <= rd_addr + 32'(ADDR_STEP);
                rd_idx  <= rd_idx + BEAT_W'(1);
            end
        end
    end

    // Stage p1: framing tags travel with the read that returns this cycle
    always_ff @(posedge clk) begin
        if (rd_en) begin
            sop_p1   <= (rd_idx == '0);
            eop_p1   <= last_rd;
            empty_p1 <= last_rd ? empty_last : 2'd0;
        end
    end

    assign push_beat = '{data: rd_data, sop: sop_p1, eop: eop_p1, empty: empty_p1};
    assign pop       = valid && ready;

    st_skid_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (rd_vld_p1),
        .push_beat(push_beat),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    // Stage p2: registered FIFO head drives the stream
    assign valid    = (fifo_count != '0);
    assign data_out = head.data;
    assign sop      = head.sop;
    assign eop      = head.eop;
    assign empty    = head.empty;

`ifdef PKT_STREAMER_STATS_EN
    logic [11:0] frame_bytes;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? '1 : s[63:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tx_packets  <= '0;
            tx_bytes    <= '0;
            frame_bytes <= '0;
        end else begin
            if (accept) begin
                frame_bytes <= len_c;
            end
            if (pop && head.eop) begin
                tx_packets <= sat_add(tx_packets, 64'd1);
                tx_bytes   <= sat_add(tx_bytes, 64'(frame_bytes));
            end
        end
    end
`endif

endmodule

// File: tb/tb_packet_streamer.sv
// Randomized bench for packet_streamer: memory model, frame-level scoreboard and
// backpressure/latency checks; stats counters checked when PKT_STREAMER_STATS_EN is set.
module tb_packet_streamer;

    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  em;
    } exp_beat_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [11:0] byte_len = '0;
    logic        busy, done, rd_en, valid, sop, eop;
    logic [31:0] rd_addr, data_out;
    logic [31:0] rd_data = '0;
    logic        ready = 1'b0;
    logic [1:0]  empty;
`ifdef PKT_STREAMER_STATS_EN
    logic [63:0] tx_packets, tx_bytes;
`endif

    always #5 clk = ~clk;

    packet_streamer dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .base_addr(base_addr),
        .byte_len (byte_len),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .sop      (sop),
        .eop      (eop),
        .empty    (empty)
`ifdef PKT_STREAMER_STATS_EN
        ,
        .tx_packets(tx_packets),
        .tx_bytes  (tx_bytes)
`endif
    );

    logic [31:0] mem [0:4095];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[13:2]];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    exp_beat_t   exp_q[$];
    logic [31:0] rd_q[$];
    int          cyc = 0, start_cyc = 0, first_rd = -1, first_vld = -1;
    int          done_cyc = 0, last_xfer_cyc = 0;
    int          beats_seen = 0, reads_seen = 0, done_seen = 0;
    logic [31:0] cur_base = '0;
    int          cur_len = 0, cur_words = 0;
    logic        prev_stall = 1'b0;
    exp_beat_t   prev;
    int          rmode = 0, pidx = 0;
    logic [3:0]  pat = 4'b1001;

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_beat_t b;
        cyc++;
        if (n_rst) begin
            if (prev_stall) chk("hold", 64'({valid, data_out, sop, eop, empty}), 64'({1'b1, prev}));
            if (start && !busy) begin
                start_cyc = cyc; first_rd = -1; first_vld = -1;
            end
            if (rd_en) begin
                chk("room", 64'((reads_seen - beats_seen) < FIFO_DEPTH), 64'd1);
                rd_q.push_back(rd_addr);
                if (first_rd < 0) first_rd = cyc;
                reads_seen++;
            end
            if (valid && first_vld < 0) first_vld = cyc;
            if (done) begin
                done_seen++; done_cyc = cyc;
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
                else begin
                    b = exp_q.pop_front();
                    chk("beat", 64'({data_out, sop, eop, empty}), 64'(b));
                end
                if (beats_seen == 25 && cur_len == 200)
                    chk("beat25", 64'(data_out), 64'(mem[(cur_base + 100) >> 2]));
                beats_seen++;
                last_xfer_cyc = cyc;
            end
            prev_stall = valid && !ready;
            prev = '{d: data_out, s: sop, e: eop, em: empty};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0:       ready = 1'b1;
            1:       begin ready = pat[pidx % 4]; pidx++; end
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_stream", 64'({data_out, valid, sop, eop, empty}), 64'd0);
`ifdef PKT_STREAMER_STATS_EN
        chk("rst_tx_packets", tx_packets, 64'd0);
        chk("rst_tx_bytes", tx_bytes, 64'd0);
`endif
        tick();
        n_rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic start_frame(input logic [31:0] b, input int len);
        int L, w;
        exp_beat_t e;
        tick();
        L = (len > 2048) ? 2048 : len;
        w = (L + 3) / 4;
        cur_base = b; cur_len = L; cur_words = w;
        beats_seen = 0; reads_seen = 0; done_seen = 0;
        rd_q.delete();
        for (int k = 0; k < w; k++) begin
            e.d  = mem[(b >> 2) + k];
            e.s  = (k == 0);
            e.e  = (k == w - 1);
            e.em = (k == w - 1) ? 2'((4 - L % 4) % 4) : 2'd0;
            exp_q.push_back(e);
        end
        start = 1'b1;
        base_addr = b;
        byte_len = 12'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic end_checks(input int ok);
        chk("done_seen", 64'(ok), 64'd1);
        chk("beats", 64'(beats_seen), 64'(cur_words));
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("done_once", 64'(done_seen), 64'd1);
        chk("done_lat", 64'(done_cyc - last_xfer_cyc), 64'd1);
        chk("rd_lat", 64'(first_rd - start_cyc), 64'd1);
        chk("vld_lat", 64'(first_vld - start_cyc), 64'd3);
        chk("reads", 64'(rd_q.size()), 64'(cur_words));
        foreach (rd_q[i]) chk("rd_addr", 64'(rd_q[i]), 64'(cur_base + 32'(4 * i)));
    endtask

    initial begin
        int ok;
        int stopped;
        int restart;
        logic [31:0] b;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;

        do_reset();

        rmode = 0;
        start_frame(32'h100, 13);
        wait_done(200, ok);
        end_checks(ok);

        rmode = 1; pidx = 0;
        start_frame(32'h200, 8);
        wait_done(200, ok);
        end_checks(ok);

        rmode = 0;
        start_frame(32'h300, 4);
        wait_done(200, ok);
        end_checks(ok);

        start_frame(32'h340, 0);
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_valid", 64'(valid), 64'd0);
        tick();
        @(negedge clk);
        chk("zero_done_clr", 64'(done), 64'd0);
        chk("zero_busy_clr", 64'(busy), 64'd0);
        tick();
        tick();
        chk("zero_reads", 64'(reads_seen), 64'd0);
        chk("zero_beats", 64'(beats_seen), 64'd0);

        rmode = 2;
        for (int f = 0; f < 5; f++) begin
            b = 32'($urandom_range(0, 12'hC00)) << 2;
            start_frame(b, $urandom_range(1, 64));
            wait_done(600, ok);
            end_checks(ok);
        end

        start_frame(32'h400, 200);
        stopped = 0;
        restart = 0;
        for (int i = 0; i < 2000 && stopped == 0; i++) begin
            @(negedge clk);
            if (beats_seen >= 30) stopped = 1;
            else if (beats_seen >= 10 && restart == 0) begin
                restart = 1;
                chk("busy_mid", 64'(busy), 64'd1);
                tick();
                start = 1'b1; base_addr = 32'h800; byte_len = 12'd16;
                tick();
                start = 1'b0;
            end else tick();
        end
        if (stopped == 0) chk("t5_timeout", 64'd0, 64'd1);
        chk("t5_no_done", 64'(done_seen), 64'd0);
        tick();
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        tick();
        n_rst = 1'b1;
        exp_q.delete();
        reads_seen = 0; beats_seen = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_no_done", 64'(done_seen), 64'd0);
        chk("abort_no_reads", 64'(reads_seen), 64'd0);
        chk("abort_no_beats", 64'(beats_seen), 64'd0);

        start_frame(32'h600, 13);
        wait_done(400, ok);
        end_checks(ok);
        start_frame(32'h1000, 200);
        wait_done(2000, ok);
        end_checks(ok);
`ifdef PKT_STREAMER_STATS_EN
        chk("tx_packets", tx_packets, 64'd2);
        chk("tx_bytes", tx_bytes, 64'd213);
`endif

        rmode = 0;
        start_frame(32'h0, 3000);
        wait_done(3000, ok);
        end_checks(ok);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
